// File: rtl/turbo_enc_pkg.sv
// Shared types and constants for the framed turbo encoder.
//   enc_state_t : frame phase (load, systematic/parity, two tail phases)
//   G0_FB/G1_FF : RSC feedback/feed-forward polynomials, bit i = coefficient of D^i
//   *_DEF       : default frame length and QPP coefficients
//   TAIL_LEN    : trellis termination beats per constituent encoder
package turbo_enc_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ENC   = 2'd1,
    TAIL1 = 2'd2,
    TAIL2 = 2'd3
  } enc_state_t;

  // 1 + D^2 + D^3 feedback, 1 + D + D^3 feed-forward
  localparam logic [3:0] G0_FB = 4'b1101;
  localparam logic [3:0] G1_FF = 4'b1011;

  localparam int unsigned K_DEF    = 40;
  localparam int unsigned F1_DEF   = 3;
  localparam int unsigned F2_DEF   = 10;
  localparam int unsigned TAIL_LEN = 3;

endpackage

// File: rtl/rsc_enc4.sv
// Recursive systematic convolutional encoder, 8-state constituent code.
//   clk, rst : clock, async active-high reset (state -> 000)
//   u        : data input bit
//   adv      : advance the trellis by one step
//   term     : termination mode; input is replaced by the feedback bit
//   z        : parity bit for the current step
//   u_t      : tail (systematic) bit emitted while terminating
module rsc_enc4
  import turbo_enc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic u,
  input  logic adv,
  input  logic term,
  output logic z,
  output logic u_t
);

  // s[0] = s0 (one delay) .. s[2] = s2 (three delays)
  logic [2:0] s;
  logic       fb;
  logic       u_eff;
  logic       a;

  assign fb    = ^(s & G0_FB[3:1]);
  assign u_t   = fb;
  // Feeding the feedback bit back in forces a = 0, flushing the register
  assign u_eff = term ? fb : u;
  assign a     = u_eff ^ fb;
  assign z     = (G1_FF[0] & a) ^ (^(s & G1_FF[3:1]));

  // Trellis state shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= 3'b000;
    end else if (adv) begin
      s <= {s[1], s[0], a};
    end
  end

endmodule

// File: rtl/turbo_enc_frame.sv
// Framed rate-1/3 turbo encoder with QPP interleaver and trellis termination.
//   clk, rst             : clock, async active-high reset
//   in_bit/in_valid/in_ready : bit-serial frame input (accepted only while loading)
//   out_data             : {sys, p1, p2} beat, decoded from registered state
//   out_valid/out_ready  : output handshake
//   out_sof/out_eof      : first systematic beat / last tail beat of a frame
//   busy                 : a frame is being loaded or encoded
module turbo_enc_frame
  import turbo_enc_pkg::*;
#(
  parameter int unsigned K  = K_DEF,
  parameter int unsigned F1 = F1_DEF,
  parameter int unsigned F2 = F2_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       out_eof,
  output logic       busy
);

  localparam int unsigned IDXW   = $clog2(K);
  localparam int unsigned IDXW1  = IDXW + 1;
  localparam int unsigned G_INIT = (F1 + F2) % K;
  localparam int unsigned G_STEP = (2 * F2) % K;

  localparam logic [IDXW:0]   K_X       = IDXW1'(K);
  localparam logic [IDXW:0]   G_STEP_X  = IDXW1'(G_STEP);
  localparam logic [IDXW-1:0] G_INIT_X  = IDXW'(G_INIT);
  localparam logic [IDXW-1:0] LAST_BIT  = IDXW'(K - 1);
  localparam logic [IDXW-1:0] LAST_TAIL = IDXW'(TAIL_LEN - 1);
  localparam logic [IDXW-1:0] PRE_TAIL  = IDXW'(TAIL_LEN - 2);

  enc_state_t      state;
  logic [IDXW-1:0] cnt;
  logic [IDXW-1:0] pi;
  logic [IDXW-1:0] g;
  logic [K-1:0]    frame_buf;

  logic load_fire;
  logic out_fire;

  assign load_fire = (state == LOAD) && in_valid;
  assign out_fire  = out_valid && out_ready;

  // Frame storage carries no reset; contents are rewritten every frame
  always_ff @(posedge clk) begin
    if (load_fire) begin
      frame_buf[cnt] <= in_bit;
    end
  end

  // Incremental QPP address: pi += g, g += 2*f2, each reduced by one subtract
  logic [IDXW:0]   pi_sum;
  logic [IDXW:0]   g_sum;
  logic [IDXW-1:0] pi_nxt;
  logic [IDXW-1:0] g_nxt;

  always_comb begin
    pi_sum = {1'b0, pi} + {1'b0, g};
    g_sum  = {1'b0, g} + G_STEP_X;
    pi_nxt = (pi_sum >= K_X) ? IDXW'(pi_sum - K_X) : IDXW'(pi_sum);
    g_nxt  = (g_sum  >= K_X) ? IDXW'(g_sum  - K_X) : IDXW'(g_sum);
  end

  // Constituent encoders: RSC1 in natural order, RSC2 through the interleaver
  logic u1, u2, z1, z2, ut1, ut2;
  logic adv1, adv2, term1, term2;

  assign u1    = frame_buf[cnt];
  assign u2    = frame_buf[pi];
  assign term1 = (state == TAIL1);
  assign term2 = (state == TAIL2);
  assign adv1  = out_fire && ((state == ENC) || term1);
  assign adv2  = out_fire && ((state == ENC) || term2);

  rsc_enc4 u_rsc1 (
    .clk  (clk),
    .rst  (rst),
    .u    (u1),
    .adv  (adv1),
    .term (term1),
    .z    (z1),
    .u_t  (ut1)
  );

  rsc_enc4 u_rsc2 (
    .clk  (clk),
    .rst  (rst),
    .u    (u2),
    .adv  (adv2),
    .term (term2),
    .z    (z2),
    .u_t  (ut2)
  );

  // Beat payload is a pure mux of registered state, so it is stable under stall
  always_comb begin
    out_data = 3'b000;
    case (state)
      ENC:     out_data = {u1, z1, z2};
      TAIL1:   out_data = {ut1, z1, 1'b0};
      TAIL2:   out_data = {ut2, 1'b0, z2};
      default: out_data = 3'b000;
    endcase
  end

  // Frame sequencer with registered handshake/framing outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      pi        <= '0;
      g         <= G_INIT_X;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            busy <= 1'b1;
            if (cnt == LAST_BIT) begin
              state     <= ENC;
              cnt       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sof   <= 1'b1;
            end else begin
              cnt <= cnt + IDXW'(1);
            end
          end
        end
        ENC: begin
          if (out_ready) begin
            pi      <= pi_nxt;
            g       <= g_nxt;
            out_sof <= 1'b0;
            if (cnt == LAST_BIT) begin
              state <= TAIL1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + IDXW'(1);
            end
          end
        end
        TAIL1: begin
          if (out_ready) begin
            if (cnt == LAST_TAIL) begin
              state <= TAIL2;
              cnt   <= '0;
            end else begin
              cnt <= cnt + IDXW'(1);
            end
          end
        end
        TAIL2: begin
          if (out_ready) begin
            if (cnt == LAST_TAIL) begin
              state     <= LOAD;
              cnt       <= '0;
              pi        <= '0;
              g         <= G_INIT_X;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_eof   <= 1'b0;
              busy      <= 1'b0;
            end else begin
              cnt <= cnt + IDXW'(1);
              if (cnt == PRE_TAIL) begin
                out_eof <= 1'b1;
              end
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_turbo_enc_frame.sv
// Self-checking bench for turbo_enc_frame against a polynomial-recursion reference.
module tb_turbo_enc_frame;

  localparam int unsigned K  = 40;
  localparam int unsigned F1 = 3;
  localparam int unsigned F2 = 10;
  localparam int unsigned NB = K + 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic       out_eof;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_beat [NB];
  logic [2:0] obs_beat [NB];
  logic [2:0] ref_beat [NB];
  logic [K-1:0] d;

  always #5 clk = ~clk;

  turbo_enc_frame #(.K(K), .F1(F1), .F2(F2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Code polynomials as sequence recursions: a[n] = u[n]^a[n-2]^a[n-3],
  // parity = a[n]^a[n-1]^a[n-3]; tail input chosen so that a[n] = 0.
  function automatic void rsc_ref(input logic [K-1:0] u, output logic [K+2:0] par,
                                  output logic [2:0] tail);
    bit a [K+3];
    bit am1, am2, am3, un;
    par  = '0;
    tail = '0;
    for (int n = 0; n < int'(K) + 3; n++) begin
      am1 = (n >= 1) ? a[n-1] : 1'b0;
      am2 = (n >= 2) ? a[n-2] : 1'b0;
      am3 = (n >= 3) ? a[n-3] : 1'b0;
      un  = (n < int'(K)) ? u[n] : (am2 ^ am3);
      a[n]   = un ^ am2 ^ am3;
      par[n] = a[n] ^ am1 ^ am3;
      if (n >= int'(K)) tail[n-int'(K)] = un;
    end
  endfunction

  function automatic void build_model(input logic [K-1:0] din);
    logic [K-1:0] il;
    logic [K+2:0] p1, p2;
    logic [2:0]   t1, t2;
    for (int i = 0; i < int'(K); i++) il[i] = din[(F1 * i + F2 * i * i) % K];
    rsc_ref(din, p1, t1);
    rsc_ref(il,  p2, t2);
    for (int i = 0; i < int'(K); i++) exp_beat[i] = {din[i], p1[i], p2[i]};
    for (int j = 0; j < 3; j++) begin
      exp_beat[K+j]   = {t1[j], p1[K+j], 1'b0};
      exp_beat[K+3+j] = {t2[j], 1'b0, p2[K+j]};
    end
  endfunction

  // Load one frame and collect its beats; stop_at >= 0 aborts after that many beats.
  task automatic run_frame(input logic [K-1:0] din, input int rdy_pct, input bit keep_valid,
                           input int stop_at);
    int acc = 0, beats = 0, cyc = 0, last_in = -100, extra = 0;
    bit seen = 0, stalled = 0;
    logic [2:0] held = 3'b000;
    build_model(din);
    while (beats < int'(NB) && !(stop_at >= 0 && beats == stop_at) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("start_in_ready", 32'(in_ready), 32'd1);
        chk("start_busy", 32'(busy), 32'd0);
        chk("start_out_valid", 32'(out_valid), 32'd0);
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          chk("first_beat_latency", 32'(cyc - last_in), 32'd1);
        end
        if (stalled) chk("stall_hold", 32'(out_data), 32'(held));
        chk($sformatf("beat%0d_data", beats), 32'(out_data), 32'(exp_beat[beats]));
        chk($sformatf("beat%0d_sof", beats), 32'(out_sof), 32'(beats == 0));
        chk($sformatf("beat%0d_eof", beats), 32'(out_eof), 32'(beats == int'(NB) - 1));
        chk("in_ready_while_encoding", 32'(in_ready), 32'd0);
        chk("busy_while_encoding", 32'(busy), 32'd1);
        obs_beat[beats] = out_data;
      end
      if (acc < int'(K)) begin
        in_valid = 1'b1;
        in_bit   = din[acc];
      end else begin
        in_valid = keep_valid;
        in_bit   = 1'($urandom);
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      if (in_ready && in_valid) begin
        if (acc < int'(K)) begin
          acc++;
          if (acc == int'(K)) last_in = cyc;
        end else begin
          extra++;
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (out_valid && out_ready) beats++;
    end
    chk("frame_timeout", 32'(cyc >= 4000), 32'd0);
    chk("bits_accepted", 32'(acc), 32'(K));
    chk("bits_outside_load", 32'(extra), 32'd0);
    if (stop_at < 0) chk("beat_count", 32'(beats), 32'(NB));
  endtask

  logic [2:0] imp0 [7];

  initial begin
    imp0 = '{3'b111, 3'b011, 3'b011, 3'b011, 3'b000, 3'b000, 3'b011};
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_sof_eof", 32'({out_sof, out_eof}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // All-zero frame
    run_frame('0, 100, 1'b0, -1);

    // Impulse at bit 0 against hand-derived beats
    d = '0; d[0] = 1'b1;
    run_frame(d, 100, 1'b0, -1);
    for (int i = 0; i < 7; i++) chk($sformatf("imp0_beat%0d", i), 32'(obs_beat[i]), 32'(imp0[i]));

    // Impulse at bit 13: pi(1) = 13, so p2 starts at beat 1
    d = '0; d[13] = 1'b1;
    run_frame(d, 100, 1'b0, -1);
    chk("imp13_p2_beat0", 32'(obs_beat[0][0]), 32'd0);
    chk("imp13_p2_beat1", 32'(obs_beat[1][0]), 32'd1);
    chk("imp13_sys_beat12", 32'(obs_beat[12][2]), 32'd0);
    chk("imp13_sys_beat13", 32'(obs_beat[13][2]), 32'd1);

    // Impulse at bit 6: pi(2) = 6
    d = '0; d[6] = 1'b1;
    run_frame(d, 100, 1'b0, -1);
    chk("imp6_p2_beat1", 32'(obs_beat[1][0]), 32'd0);
    chk("imp6_p2_beat2", 32'(obs_beat[2][0]), 32'd1);

    // Random frames, full rate then 50% backpressure
    for (int r = 0; r < 3; r++) begin
      d = K'({$urandom, $urandom});
      run_frame(d, 100, 1'b0, -1);
      ref_beat = obs_beat;
      run_frame(d, 50, 1'b0, -1);
      for (int i = 0; i < int'(NB); i++)
        chk($sformatf("bp_r%0d_beat%0d", r, i), 32'(obs_beat[i]), 32'(ref_beat[i]));
    end

    // Reset in the middle of ENC
    d = K'({$urandom, $urandom});
    run_frame(d, 100, 1'b0, 20);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sof_eof", 32'({out_sof, out_eof}), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    d = K'({$urandom, $urandom});
    run_frame(d, 100, 1'b0, -1);

    // Back-to-back frames with in_valid held high
    for (int r = 0; r < 3; r++) begin
      d = K'({$urandom, $urandom});
      run_frame(d, (r == 1) ? 70 : 100, 1'b1, -1);
    end
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
